// File: rtl/gshare_bp_param.sv
`timescale 1ns/1ps
// gshare direction predictor with a tagged, typed direct-mapped BTB, speculative GHR and perf counters.
// Latency: prediction and redirect are combinational; table/GHR/counter writes commit on the next rising edge.
// Backpressure: none; o_busy is high while the tables are swept after reset, and predictions are forced not-taken then.
module gshare_bp_param #(
  parameter int PHT_BITS = 10,
  parameter int GHR_BITS = 10,
  parameter int BTB_BITS = 8,
  parameter int CNT_BITS = 2,
  parameter int PERF_W   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_fetch_en_F,
  input  logic [31:0]         i_pc_F,
  output logic                o_pred_taken_F,
  output logic [31:0]         o_pred_target_F,
  output logic [GHR_BITS-1:0] o_ghr_F,
  input  logic                i_br_valid_E,
  input  logic                i_jump_E,
  input  logic [31:0]         i_pc_E,
  input  logic                i_taken_E,
  input  logic [31:0]         i_target_E,
  input  logic                i_pred_taken_E,
  input  logic [31:0]         i_pred_target_E,
  input  logic [GHR_BITS-1:0] i_ghr_E,
  output logic                o_redirect_E,
  output logic [31:0]         o_redirect_pc_E,
  output logic                o_busy,
  output logic [PERF_W-1:0]   o_br_cnt,
  output logic [PERF_W-1:0]   o_mp_cnt
);

  localparam int IDX_BITS = (PHT_BITS > BTB_BITS) ? PHT_BITS : BTB_BITS;
  localparam int TAG_BITS = 30 - BTB_BITS;
  localparam int PHT_N    = 1 << PHT_BITS;
  localparam int BTB_N    = 1 << BTB_BITS;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_BITS-1:0] CNT_WNT = {1'b0, {(CNT_BITS-1){1'b1}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q;
  logic                  busy_q;
  logic [IDX_BITS-1:0]   init_idx_q;

  logic [CNT_BITS-1:0]   pht_q     [PHT_N];
  logic                  btb_vld_q [BTB_N];
  logic [TAG_BITS-1:0]   btb_tag_q [BTB_N];
  logic [31:0]           btb_tgt_q [BTB_N];
  logic                  btb_jmp_q [BTB_N];

  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [PERF_W-1:0]     br_cnt_q, br_cnt_d;
  logic [PERF_W-1:0]     mp_cnt_q, mp_cnt_d;

  logic [PHT_BITS-1:0]   ghr_f_ext, ghr_e_ext;
  logic [PHT_BITS-1:0]   pidx_f, pidx_e;
  logic [BTB_BITS-1:0]   bidx_f, bidx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, jmp_f, taken_f;
  logic                  mp_br, mp_jmp, redirect;
  logic [CNT_BITS-1:0]   pht_old, pht_new;
  logic                  pht_we, btb_we, resolve;
  logic [GHR_BITS:0]     ghr_f_shl, ghr_e_shl;
  logic                  unused_ok;

  // Zero-extend both histories to the PHT index width.
  always_comb begin
    ghr_f_ext = '0;
    ghr_f_ext[GHR_BITS-1:0] = ghr_q;
    ghr_e_ext = '0;
    ghr_e_ext[GHR_BITS-1:0] = i_ghr_E;
  end

  assign pidx_f  = i_pc_F[PHT_BITS+1:2] ^ ghr_f_ext;
  assign bidx_f  = i_pc_F[BTB_BITS+1:2];
  assign tag_f   = i_pc_F[31:BTB_BITS+2];
  assign hit_f   = btb_vld_q[bidx_f] && (btb_tag_q[bidx_f] == tag_f);
  assign jmp_f   = btb_jmp_q[bidx_f];
  assign taken_f = !busy_q && hit_f && (jmp_f || pht_q[pidx_f][CNT_BITS-1]);

  assign o_pred_taken_F  = taken_f;
  assign o_pred_target_F = taken_f ? btb_tgt_q[bidx_f] : (i_pc_F + 32'd4);
  assign o_ghr_F         = ghr_q;

  assign pidx_e = i_pc_E[PHT_BITS+1:2] ^ ghr_e_ext;
  assign bidx_e = i_pc_E[BTB_BITS+1:2];
  assign tag_e  = i_pc_E[31:BTB_BITS+2];

  // Redirect is evaluated even during init so fetch still recovers correctly.
  assign mp_br    = i_br_valid_E && ((i_taken_E != i_pred_taken_E) ||
                                     (i_taken_E && (i_target_E != i_pred_target_E)));
  assign mp_jmp   = i_jump_E && (!i_pred_taken_E || (i_target_E != i_pred_target_E));
  assign redirect = mp_br || mp_jmp;

  assign o_redirect_E    = redirect;
  assign o_redirect_pc_E = (i_jump_E || i_taken_E) ? i_target_E : (i_pc_E + 32'd4);

  assign pht_we  = !busy_q && i_br_valid_E;
  assign btb_we  = !busy_q && ((i_br_valid_E && i_taken_E) || i_jump_E);
  assign resolve = !busy_q && (i_br_valid_E || i_jump_E);
  assign pht_old = pht_q[pidx_e];

  // Saturating up/down step of the resolving branch's counter.
  always_comb begin
    pht_new = pht_old;
    if (i_taken_E) begin
      if (pht_old != {CNT_BITS{1'b1}}) pht_new = pht_old + 1'b1;
    end else if (pht_old != '0) begin
      pht_new = pht_old - 1'b1;
    end
  end

  // Init/run sequencer: one table index swept per cycle, then run.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      busy_q     <= 1'b1;
      init_idx_q <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == {IDX_BITS{1'b1}}) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Table storage: swept during init, otherwise written by resolving branches/jumps.
  always_ff @(posedge i_clk) begin
    if (busy_q) begin
      pht_q[init_idx_q[PHT_BITS-1:0]]     <= CNT_WNT;
      btb_vld_q[init_idx_q[BTB_BITS-1:0]] <= 1'b0;
    end else begin
      if (pht_we) pht_q[pidx_e] <= pht_new;
      if (btb_we) begin
        btb_vld_q[bidx_e] <= 1'b1;
        btb_tag_q[bidx_e] <= tag_e;
        btb_tgt_q[bidx_e] <= i_target_E;
        btb_jmp_q[bidx_e] <= i_jump_E;
      end
    end
  end

  assign ghr_f_shl = {ghr_q, taken_f};
  assign ghr_e_shl = {i_ghr_E, i_taken_E};

  // Next history: recovery from E wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (!busy_q) begin
      if (redirect) begin
        ghr_d = i_jump_E ? i_ghr_E : ghr_e_shl[GHR_BITS-1:0];
      end else if (i_fetch_en_F && hit_f && !jmp_f) begin
        ghr_d = ghr_f_shl[GHR_BITS-1:0];
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && (br_cnt_q != {PERF_W{1'b1}})) br_cnt_d = br_cnt_q + 1'b1;
    if (!busy_q && redirect && (mp_cnt_q != {PERF_W{1'b1}})) mp_cnt_d = mp_cnt_q + 1'b1;
  end

  // History and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ghr_q    <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      ghr_q    <= ghr_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_br_cnt = br_cnt_q;
  assign o_mp_cnt = mp_cnt_q;

  // Byte-offset PC bits and the shifted-out history bits carry no information here.
  assign unused_ok = ^{i_pc_F[1:0], i_pc_E[1:0], ghr_f_shl[GHR_BITS], ghr_e_shl[GHR_BITS]};

endmodule

// File: tb/tb_gshare_bp_param.sv
`timescale 1ns/1ps
// Randomized + directed bench for gshare_bp_param against a table-level reference model.
// Latency: checks combinational outputs mid-cycle, model commits after each rising edge.
// Backpressure: none; init phase is waited out with a bounded loop.
module tb_gshare_bp_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc_F;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [9:0]  ghr_F;
  logic        br_valid, jump, taken, pred_taken_E;
  logic [31:0] pc_E, target, pred_target_E;
  logic [9:0]  ghr_E;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;
  logic [31:0] br_cnt, mp_cnt;

  gshare_bp_param dut (
    .i_clk(clk), .i_rst(rst),
    .i_fetch_en_F(fetch_en), .i_pc_F(pc_F),
    .o_pred_taken_F(pred_taken), .o_pred_target_F(pred_target), .o_ghr_F(ghr_F),
    .i_br_valid_E(br_valid), .i_jump_E(jump), .i_pc_E(pc_E), .i_taken_E(taken),
    .i_target_E(target), .i_pred_taken_E(pred_taken_E), .i_pred_target_E(pred_target_E),
    .i_ghr_E(ghr_E),
    .o_redirect_E(redirect), .o_redirect_pc_E(redirect_pc),
    .o_busy(busy), .o_br_cnt(br_cnt), .o_mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int n;
  int g;

  // Reference model: plain arrays indexed by the documented hash rules.
  int          pht_m [1024];
  bit          vld_m [256];
  logic [31:0] tag_m [256];
  logic [31:0] tgt_m [256];
  bit          jmp_m [256];
  int          ghr_m;
  int          brc_m, mpc_m;
  logic [31:0] pool [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 1024; i++) pht_m[i] = 1;
    for (int i = 0; i < 256; i++) vld_m[i] = 1'b0;
    ghr_m = 0; brc_m = 0; mpc_m = 0;
  endtask

  task automatic mpred(input logic [31:0] pc, input int gh, output bit hit, output bit tk,
                       output logic [31:0] tg, output bit jb);
    int bi, pi;
    bi  = int'((pc >> 2) & 32'hFF);
    pi  = int'((pc >> 2) & 32'h3FF) ^ gh;
    hit = vld_m[bi] && (tag_m[bi] == (pc >> 10));
    jb  = jmp_m[bi];
    tk  = hit && (jb || pht_m[pi] >= 2);
    tg  = tk ? tgt_m[bi] : pc + 32'd4;
  endtask

  function automatic bit model_mp();
    if (br_valid) return (taken != pred_taken_E) || (taken && target != pred_target_E);
    if (jump)     return !pred_taken_E || target != pred_target_E;
    return 1'b0;
  endfunction

  task automatic commit();
    bit h, t, j, mp;
    logic [31:0] tg;
    int gn, pi, bi;
    mpred(pc_F, ghr_m, h, t, tg, j);
    mp = model_mp();
    gn = ghr_m;
    if (fetch_en && h && !j && !mp) gn = ((ghr_m << 1) | int'(t)) & 1023;
    pi = int'((pc_E >> 2) & 32'h3FF) ^ int'(ghr_E);
    bi = int'((pc_E >> 2) & 32'hFF);
    if (br_valid) begin
      if (taken && pht_m[pi] < 3) pht_m[pi]++;
      else if (!taken && pht_m[pi] > 0) pht_m[pi]--;
      if (taken) begin
        vld_m[bi] = 1'b1; tag_m[bi] = pc_E >> 10; tgt_m[bi] = target; jmp_m[bi] = 1'b0;
      end
      if (mp) gn = ((int'(ghr_E) << 1) | int'(taken)) & 1023;
    end
    if (jump) begin
      vld_m[bi] = 1'b1; tag_m[bi] = pc_E >> 10; tgt_m[bi] = target; jmp_m[bi] = 1'b1;
      if (mp) gn = int'(ghr_E);
    end
    if (br_valid || jump) brc_m++;
    if (mp) mpc_m++;
    ghr_m = gn;
  endtask

  task automatic drive_idle();
    fetch_en = 0; pc_F = 0; br_valid = 0; jump = 0; pc_E = 0; taken = 0;
    target = 0; pred_taken_E = 0; pred_target_E = 0; ghr_E = 0;
  endtask

  task automatic cycle();
    bit h, t, j;
    logic [31:0] tg;
    #1;
    mpred(pc_F, ghr_m, h, t, tg, j);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, t});
    chk("pred_target", pred_target, tg);
    chk("ghr", {22'b0, ghr_F}, ghr_m);
    chk("redirect", {31'b0, redirect}, {31'b0, model_mp()});
    if (br_valid || jump)
      chk("redirect_pc", redirect_pc, (jump || taken) ? target : pc_E + 32'd4);
    chk("busy", {31'b0, busy}, 32'd0);
    chk("br_cnt", br_cnt, brc_m);
    chk("mp_cnt", mp_cnt, mpc_m);
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic rand_cycle();
    bit h, t, j;
    logic [31:0] tg;
    int k;
    fetch_en = ($urandom % 4) != 0;
    pc_F     = pool[$urandom % 8];
    k        = $urandom % 4;
    br_valid = (k == 1) || (k == 2);
    jump     = (k == 3);
    pc_E     = pool[$urandom % 8];
    taken    = $urandom % 2;
    target   = ($urandom % 2) ? pool[$urandom % 8] : 32'h1000 + (($urandom % 64) << 2);
    ghr_E    = ($urandom % 2) ? ghr_m[9:0] : 10'($urandom);
    if ($urandom % 2) begin
      mpred(pc_E, int'(ghr_E), h, t, tg, j);
      pred_taken_E = t; pred_target_E = tg;
    end else begin
      pred_taken_E  = $urandom % 2;
      pred_target_E = ($urandom % 2) ? target : pool[$urandom % 8];
    end
    cycle();
  endtask

  task automatic wait_init(input string tag, input bit inject);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1; n++;
      if (inject && n == 1000) begin
        br_valid = 1; pc_E = 32'h100; taken = 1; target = 32'h40;
        pred_taken_E = 0; pred_target_E = 32'h104; ghr_E = 0;
        #1;
        chk("init_redirect", {31'b0, redirect}, 32'd1);
        chk("init_redirect_pc", redirect_pc, 32'h40);
      end else if (n == 1001) begin
        drive_idle();
      end
    end
    chk(tag, n, 32'd1024);
    chk("init_br_cnt", br_cnt, 32'd0);
    chk("init_mp_cnt", mp_cnt, 32'd0);
    chk("init_ghr", {22'b0, ghr_F}, 32'd0);
  endtask

  initial begin
    pool[0] = 32'h100;  pool[1] = 32'h200;  pool[2] = 32'h300;  pool[3] = 32'h500;
    pool[4] = 32'h104;  pool[5] = 32'hFFFF_FFFC; pool[6] = 32'h1040; pool[7] = 32'h2100;
    rst = 1; drive_idle();
    #12;
    fetch_en = 1; pc_F = 32'h100; #1;
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ghr", {22'b0, ghr_F}, 32'd0);
    chk("rst_br_cnt", br_cnt, 32'd0);
    chk("rst_mp_cnt", mp_cnt, 32'd0);
    chk("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h104);
    drive_idle();

    @(negedge clk); rst = 0; #1;
    chk("init_busy_start", {31'b0, busy}, 32'd1);
    wait_init("init_len", 1'b1);
    model_init();
    @(negedge clk);

    // Branch 0x100 -> 0x40 resolved taken three times with history 0.
    for (int i = 0; i < 3; i++) begin
      br_valid = 1; pc_E = 32'h100; taken = 1; target = 32'h40; ghr_E = 0;
      pred_taken_E = (i != 0); pred_target_E = (i != 0) ? 32'h40 : 32'h104;
      cycle();
    end
    drive_idle(); #1;
    chk("d1_mp_cnt", mp_cnt, 32'd1);
    chk("d1_br_cnt", br_cnt, 32'd3);

    // First jump 0x200 -> 0x800; its recovery also restores history to 0.
    jump = 1; pc_E = 32'h200; target = 32'h800; pred_taken_E = 0;
    pred_target_E = 32'h204; ghr_E = 0; #1;
    chk("d2_redirect", {31'b0, redirect}, 32'd1);
    chk("d2_redirect_pc", redirect_pc, 32'h800);
    cycle(); drive_idle();

    fetch_en = 1; pc_F = 32'h100; #1;
    chk("d1_pred_taken", {31'b0, pred_taken}, 32'd1);
    chk("d1_pred_target", pred_target, 32'h40);
    cycle(); drive_idle();

    fetch_en = 1; pc_F = 32'h200; #1;
    chk("d2_pred_taken", {31'b0, pred_taken}, 32'd1);
    chk("d2_pred_target", pred_target, 32'h800);
    g = ghr_m;
    cycle(); drive_idle(); #1;
    chk("d2_noshift", {22'b0, ghr_F}, g);

    // BTB alias of 0x100 must miss.
    fetch_en = 1; pc_F = 32'h500; #1;
    chk("d3_alias_taken", {31'b0, pred_taken}, 32'd0);
    chk("d3_alias_target", pred_target, 32'h504);
    cycle(); drive_idle();

    // PC+4 wraps modulo 2**32 on both ports.
    fetch_en = 1; pc_F = 32'hFFFF_FFFC;
    br_valid = 1; pc_E = 32'hFFFF_FFFC; taken = 0; pred_taken_E = 1; pred_target_E = 32'h40; #1;
    chk("wrap_pred_target", pred_target, 32'h0);
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    cycle(); drive_idle();

    // Restore history 0, then shift and recovery in the same cycle.
    jump = 1; pc_E = 32'h200; target = 32'h800; pred_taken_E = 0; ghr_E = 0;
    cycle(); drive_idle();
    fetch_en = 1; pc_F = 32'h100;
    br_valid = 1; pc_E = 32'h300; taken = 0; target = 32'h340;
    pred_taken_E = 1; pred_target_E = 32'h340; ghr_E = 10'h155; #1;
    chk("d4_pred_taken", {31'b0, pred_taken}, 32'd1);
    chk("d4_redirect", {31'b0, redirect}, 32'd1);
    cycle(); drive_idle(); #1;
    chk("d4_ghr", {22'b0, ghr_F}, 32'h2AA);
    @(negedge clk);

    repeat (600) rand_cycle();
    drive_idle();

    // Reset mid-init restarts the sweep and clears the counters.
    @(negedge clk); rst = 1; #1;
    chk("d5_rst_busy", {31'b0, busy}, 32'd1);
    chk("d5_rst_br_cnt", br_cnt, 32'd0);
    chk("d5_rst_mp_cnt", mp_cnt, 32'd0);
    @(negedge clk); rst = 0;
    repeat (300) @(posedge clk);
    #1 rst = 1; #1;
    chk("d5_busy_mid", {31'b0, busy}, 32'd1);
    @(negedge clk); rst = 0; #1;
    wait_init("d5_init_len", 1'b0);
    model_init();
    @(negedge clk);
    repeat (100) rand_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
